// File: rtl/cache_perf_counter_pkg.sv
// Shared definitions for the cache performance counter block.
// Contents:
//   CMD_*      encodings carried on cmd_op
//   SEL_*      encodings carried on rd_sel (also the counter/sat bit index)
//   ST_*       FSM state encoding
//   NUM_CNT    number of event counters
package cache_perf_counter_pkg;

    typedef logic [1:0] cmd_op_t;
    typedef logic [1:0] rd_sel_t;

    localparam cmd_op_t CMD_START    = 2'd0;
    localparam cmd_op_t CMD_STOP     = 2'd1;
    localparam cmd_op_t CMD_CLEAR    = 2'd2;
    localparam cmd_op_t CMD_SNAPSHOT = 2'd3;

    localparam rd_sel_t SEL_I_ACCESS = 2'd0;
    localparam rd_sel_t SEL_I_MISS   = 2'd1;
    localparam rd_sel_t SEL_D_ACCESS = 2'd2;
    localparam rd_sel_t SEL_D_MISS   = 2'd3;

    localparam logic [0:0] ST_STOP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int NUM_CNT = 4;

endpackage

// File: rtl/cache_perf_counter_if.sv
// Bus bundle between a host/cache complex and cache_perf_counter.
// Signals:
//   icache_valid/icache_miss, dcache_valid/dcache_miss  cache event strobes
//   cmd_valid/cmd_op                                    START/STOP/CLEAR/SNAPSHOT
//   rd_en/rd_sel                                        shadow register read request
//   rd_data_valid/rd_data                               read response (one cycle later)
//   running                                             FSM is in RUN
//   sat                                                 sticky saturation flags, index = rd_sel
// Modports: master drives events/commands/reads, slave is the counter block.
interface cache_perf_counter_if #(
    parameter int CNT_W = 64
);
    import cache_perf_counter_pkg::*;

    logic             icache_valid;
    logic             icache_miss;
    logic             dcache_valid;
    logic             dcache_miss;
    logic             cmd_valid;
    cmd_op_t          cmd_op;
    logic             rd_en;
    rd_sel_t          rd_sel;
    logic             rd_data_valid;
    logic [CNT_W-1:0] rd_data;
    logic             running;
    logic [3:0]       sat;

    modport master (
        output icache_valid, icache_miss, dcache_valid, dcache_miss,
        output cmd_valid, cmd_op, rd_en, rd_sel,
        input  rd_data_valid, rd_data, running, sat
    );

    modport slave (
        input  icache_valid, icache_miss, dcache_valid, dcache_miss,
        input  cmd_valid, cmd_op, rd_en, rd_sel,
        output rd_data_valid, rd_data, running, sat
    );

endinterface

// File: rtl/cache_perf_counter_sat_counter.sv
// Saturating event counter with sticky overflow flag.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   clear         zero count and flag (wins over inc)
//   inc           count one event this cycle
//   count         current value, sticks at all-ones
//   sat           set when an event arrives while count is all-ones
module sat_counter
    import cache_perf_counter_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            if (count == CNT_MAX) begin
                sat <= 1'b1;
            end
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/cache_perf_counter.sv
// Cache performance counter: counts I/D cache accesses and misses while
// running, supports atomic snapshot into shadow registers and a one-cycle
// latency read port on those shadows.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    cache_perf_counter_if.slave (events, commands, reads, status)
module cache_perf_counter
    import cache_perf_counter_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input logic                 clock,
    input logic                 reset,
    cache_perf_counter_if.slave bus
);

    logic [0:0]       state_p0;
    logic [0:0]       state_next;
    logic             is_start;
    logic             is_stop;
    logic             is_clear;
    logic             is_snap;
    logic             counting;
    logic [3:0]       inc;
    logic [CNT_W-1:0] live     [NUM_CNT];
    logic [CNT_W-1:0] shadow   [NUM_CNT];
    logic [3:0]       sat_bits;
    logic             vld_p1;
    logic [CNT_W-1:0] rd_data_p1;

    assign is_start = bus.cmd_valid && (bus.cmd_op == CMD_START);
    assign is_stop  = bus.cmd_valid && (bus.cmd_op == CMD_STOP);
    assign is_clear = bus.cmd_valid && (bus.cmd_op == CMD_CLEAR);
    assign is_snap  = bus.cmd_valid && (bus.cmd_op == CMD_SNAPSHOT);

    always_comb begin
        state_next = state_p0;
        if (state_p0 == ST_STOP && is_start) begin
            state_next = ST_RUN;
        end else if (state_p0 == ST_RUN && is_stop) begin
            state_next = ST_STOP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_p0 <= ST_STOP;
        end else begin
            state_p0 <= state_next;
        end
    end

    // Events landing in a CLEAR cycle are dropped rather than counted after the clear.
    assign counting = (state_p0 == ST_RUN) && !is_clear;

    always_comb begin
        inc               = '0;
        inc[SEL_I_ACCESS] = counting && bus.icache_valid;
        inc[SEL_I_MISS]   = counting && bus.icache_valid && bus.icache_miss;
        inc[SEL_D_ACCESS] = counting && bus.dcache_valid;
        inc[SEL_D_MISS]   = counting && bus.dcache_valid && bus.dcache_miss;
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .clear (is_clear),
            .inc   (inc[i]),
            .count (live[i]),
            .sat   (sat_bits[i])
        );
    end

    // Shadow copy takes the live registers as they stand this cycle, i.e.
    // before any increment landing on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                shadow[k] <= '0;
            end
        end else if (is_snap) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                shadow[k] <= live[k];
            end
        end
    end

    // ---- read stage p1: response one cycle after rd_en, from pre-snapshot shadow ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_p1 <= shadow[bus.rd_sel];
            end
        end
    end

    assign bus.running       = (state_p0 == ST_RUN);
    assign bus.sat           = sat_bits;
    assign bus.rd_data_valid = vld_p1;
    assign bus.rd_data       = rd_data_p1;

endmodule

// File: tb/tb_cache_perf_counter.sv
// Testbench for cache_perf_counter: a 64-bit and a 4-bit instance share the
// same stimulus and are compared each cycle against a behavioural model,
// plus a directed vector table and hand-written corner sequences.
module tb_cache_perf_counter;
    import cache_perf_counter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       iv, im, dv, dm, cv, re;
    logic [1:0] op, rs;

    cache_perf_counter_if #(.CNT_W(64)) bus64 ();
    cache_perf_counter_if #(.CNT_W(4))  bus4 ();

    assign bus64.icache_valid = iv;  assign bus4.icache_valid = iv;
    assign bus64.icache_miss  = im;  assign bus4.icache_miss  = im;
    assign bus64.dcache_valid = dv;  assign bus4.dcache_valid = dv;
    assign bus64.dcache_miss  = dm;  assign bus4.dcache_miss  = dm;
    assign bus64.cmd_valid    = cv;  assign bus4.cmd_valid    = cv;
    assign bus64.cmd_op       = op;  assign bus4.cmd_op       = op;
    assign bus64.rd_en        = re;  assign bus4.rd_en        = re;
    assign bus64.rd_sel       = rs;  assign bus4.rd_sel       = rs;

    cache_perf_counter #(.CNT_W(64)) dut64 (.clock(clock), .reset(reset), .bus(bus64.slave));
    cache_perf_counter #(.CNT_W(4))  dut4  (.clock(clock), .reset(reset), .bus(bus4.slave));

    int total = 0;
    int bad   = 0;

    // Behavioural model, index 0 = 64-bit instance, 1 = 4-bit instance.
    logic [63:0] m_max    [2];
    logic [63:0] m_live   [2][4];
    logic [63:0] m_shadow [2][4];
    logic [63:0] m_rd     [2];
    logic [3:0]  m_sat    [2];
    logic        m_run;
    logic        m_rdv;

    task automatic model_step();
        logic [3:0] ev;
        if (reset) begin
            m_run = 1'b0;
            m_rdv = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_rd[d]  = '0;
                m_sat[d] = '0;
                for (int k = 0; k < 4; k++) begin
                    m_live[d][k]   = '0;
                    m_shadow[d][k] = '0;
                end
            end
            return;
        end
        ev    = {dv & dm, dv, iv & im, iv};
        m_rdv = re;
        for (int d = 0; d < 2; d++) begin
            if (re) m_rd[d] = m_shadow[d][rs];
            if (cv && op == CMD_SNAPSHOT)
                for (int k = 0; k < 4; k++) m_shadow[d][k] = m_live[d][k];
            if (cv && op == CMD_CLEAR) begin
                for (int k = 0; k < 4; k++) m_live[d][k] = '0;
                m_sat[d] = '0;
            end else if (m_run) begin
                for (int k = 0; k < 4; k++) begin
                    if (ev[k]) begin
                        if (m_live[d][k] == m_max[d]) m_sat[d][k] = 1'b1;
                        else m_live[d][k] = m_live[d][k] + 64'd1;
                    end
                end
            end
        end
        if (cv && op == CMD_START) m_run = 1'b1;
        if (cv && op == CMD_STOP)  m_run = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " rdv64"}, 64'(bus64.rd_data_valid), 64'(m_rdv));
        chk({tag, " rd64"},  bus64.rd_data,            m_rd[0]);
        chk({tag, " run64"}, 64'(bus64.running),       64'(m_run));
        chk({tag, " sat64"}, 64'(bus64.sat),           64'(m_sat[0]));
        chk({tag, " rdv4"},  64'(bus4.rd_data_valid),  64'(m_rdv));
        chk({tag, " rd4"},   64'(bus4.rd_data),        m_rd[1]);
        chk({tag, " run4"},  64'(bus4.running),        64'(m_run));
        chk({tag, " sat4"},  64'(bus4.sat),            64'(m_sat[1]));
    endtask

    task automatic drive(input logic r, input logic c, input logic [1:0] o,
                         input logic a, input logic b, input logic x, input logic y,
                         input logic e, input logic [1:0] s);
        reset = r; cv = c; op = o; iv = a; im = b; dv = x; dm = y; re = e; rs = s;
    endtask

    task automatic idle();
        drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_model(tag);
    endtask

    typedef struct {
        logic        rst, c;
        logic [1:0]  o;
        logic        a, b, x, y, e;
        logic [1:0]  s;
        logic        x_rdv;
        logic [63:0] x_data;
        logic        x_run;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic c, input logic [1:0] o,
                                input logic a, input logic b, input logic x, input logic y,
                                input logic e, input logic [1:0] s,
                                input logic x_rdv, input logic [63:0] x_data, input logic x_run);
        vec_t v;
        v.rst = rst; v.c = c; v.o = o; v.a = a; v.b = b; v.x = x; v.y = y;
        v.e = e; v.s = s; v.x_rdv = x_rdv; v.x_data = x_data; v.x_run = x_run;
        tbl.push_back(v);
    endfunction

    initial begin
        m_max[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        m_max[1] = 64'd15;
        idle();
        reset = 1'b1;

        // Reset, START, 10 I-accesses (3 misses), SNAPSHOT, read 10/3.
        add(1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 64'd0, 0);
        add(0, 1, CMD_START, 0, 0, 0, 0, 0, 2'd0, 0, 64'd0, 1);
        for (int i = 0; i < 10; i++)
            add(0, 0, 2'd0, 1, (i == 0 || i == 3 || i == 6), 0, 0, 0, 2'd0, 0, 64'd0, 1);
        add(0, 1, CMD_SNAPSHOT, 0, 0, 0, 0, 0, 2'd0, 0, 64'd0, 1);
        add(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_I_ACCESS, 1, 64'd10, 1);
        add(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_I_MISS,   1, 64'd3,  1);
        add(0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 64'd3, 1);
        // STOP, D-misses while stopped are ignored.
        add(0, 1, CMD_STOP, 0, 0, 0, 0, 0, 2'd0, 0, 64'd3, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 2'd0, 0, 0, 1, 1, 0, 2'd0, 0, 64'd3, 0);
        add(0, 1, CMD_SNAPSHOT, 0, 0, 0, 0, 0, 2'd0, 0, 64'd3, 0);
        add(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_D_ACCESS, 1, 64'd0, 0);
        add(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_D_MISS,   1, 64'd0, 0);
        // RUN, miss without valid is ignored.
        add(0, 1, CMD_START, 0, 0, 0, 0, 0, 2'd0, 0, 64'd0, 1);
        add(0, 1, CMD_CLEAR, 0, 0, 0, 0, 0, 2'd0, 0, 64'd0, 1);
        add(0, 0, 2'd0, 0, 1, 0, 1, 0, 2'd0, 0, 64'd0, 1);
        add(0, 1, CMD_SNAPSHOT, 0, 0, 0, 0, 0, 2'd0, 0, 64'd0, 1);
        add(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_I_MISS,   1, 64'd0, 1);
        add(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_I_ACCESS, 1, 64'd0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].c, tbl[i].o, tbl[i].a, tbl[i].b,
                  tbl[i].x, tbl[i].y, tbl[i].e, tbl[i].s);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d rdv", i), 64'(bus64.rd_data_valid), 64'(tbl[i].x_rdv));
            chk($sformatf("vec%0d data", i), bus64.rd_data, tbl[i].x_data);
            chk($sformatf("vec%0d run", i), 64'(bus64.running), 64'(tbl[i].x_run));
            chk($sformatf("vec%0d sat", i), 64'(bus64.sat), 64'd0);
        end

        // Saturation on the 4-bit instance.
        drive(1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0); step("sat rst");
        drive(0, 1, CMD_START, 0, 0, 0, 0, 0, 2'd0); step("sat start");
        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 2'd0, 0, 0, 1, 0, 0, 2'd0); step("sat inc");
        end
        chk("sat4 at 15", 64'(bus4.sat), 64'd0);
        drive(0, 0, 2'd0, 0, 0, 1, 0, 0, 2'd0); step("sat inc16");
        chk("sat4 at 16", 64'(bus4.sat), 64'b0100);
        drive(0, 0, 2'd0, 0, 0, 1, 0, 0, 2'd0); step("sat inc17");
        chk("sat4 at 17", 64'(bus4.sat), 64'b0100);
        chk("sat64 at 17", 64'(bus64.sat), 64'd0);
        drive(0, 1, CMD_SNAPSHOT, 0, 0, 0, 0, 0, 2'd0); step("sat snap");
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_D_ACCESS); step("sat rd");
        chk("sat rd4", 64'(bus4.rd_data), 64'd15);
        chk("sat rd64", bus64.rd_data, 64'd17);
        drive(0, 1, CMD_CLEAR, 0, 0, 0, 0, 0, 2'd0); step("sat clr");
        chk("sat4 cleared", 64'(bus4.sat), 64'd0);
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_D_ACCESS); step("sat rd2");
        chk("sat shadow kept", 64'(bus4.rd_data), 64'd15);

        // CLEAR and SNAPSHOT colliding with events.
        drive(1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0); step("col rst");
        drive(0, 1, CMD_START, 0, 0, 0, 0, 0, 2'd0); step("col start");
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 2'd0, 1, 0, 0, 0, 0, 2'd0); step("col inc");
        end
        drive(0, 1, CMD_SNAPSHOT, 1, 0, 0, 0, 0, 2'd0); step("col snap+ev");
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_I_ACCESS); step("col rd");
        chk("snap pre-inc", bus64.rd_data, 64'd7);
        drive(0, 1, CMD_SNAPSHOT, 0, 0, 0, 0, 0, 2'd0); step("col snap2");
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_I_ACCESS); step("col rd2");
        chk("live after snap", bus64.rd_data, 64'd8);
        drive(0, 1, CMD_CLEAR, 1, 0, 0, 0, 0, 2'd0); step("col clr+ev");
        drive(0, 1, CMD_SNAPSHOT, 0, 0, 0, 0, 0, 2'd0); step("col snap3");
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_I_ACCESS); step("col rd3");
        chk("clear drops ev", bus64.rd_data, 64'd0);

        // Read in the SNAPSHOT cycle returns the old shadow.
        drive(0, 0, 2'd0, 1, 0, 0, 0, 0, 2'd0); step("rs inc");
        drive(0, 0, 2'd0, 1, 0, 0, 0, 0, 2'd0); step("rs inc");
        drive(0, 1, CMD_SNAPSHOT, 0, 0, 0, 0, 1, SEL_I_ACCESS); step("rs snap+rd");
        chk("rd old shadow", bus64.rd_data, 64'd0);
        chk("rd old vld", 64'(bus64.rd_data_valid), 64'd1);
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1, SEL_I_ACCESS); step("rs rd");
        chk("rd new shadow", bus64.rd_data, 64'd2);

        // Reset mid-RUN with a read in flight.
        drive(0, 0, 2'd0, 1, 1, 1, 1, 0, 2'd0); step("mr ev");
        drive(1, 0, 2'd0, 1, 1, 1, 1, 1, SEL_I_ACCESS); step("mr rst+rd");
        chk("mr no vld", 64'(bus64.rd_data_valid), 64'd0);
        chk("mr stopped", 64'(bus64.running), 64'd0);
        drive(0, 1, CMD_SNAPSHOT, 0, 0, 0, 0, 0, 2'd0); step("mr snap");
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 2'd0, 0, 0, 0, 0, 1, 2'(k)); step("mr rd");
            chk($sformatf("mr rd%0d", k), bus64.rd_data, 64'd0);
        end

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
                  2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
                  2'($urandom_range(0, 3)));
            step("rand");
        end

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
